// File: rtl/pipe_sink_if.sv
// Handshake bundle between a pipe_reg chain tail, pipe_sink, and the downstream consumer.
// The driver side (slave) is the sink; master is whoever feeds the chain word and takes the head.
interface pipe_sink_if #(parameter int DSIZE = 8);
  logic             up_valid;
  logic [DSIZE-1:0] up_data;
  logic             low_empty;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic             out_ready;

  modport master (output up_valid, up_data, out_ready,
                  input  low_empty, out_valid, out_data);
  modport slave  (input  up_valid, up_data, out_ready,
                  output low_empty, out_valid, out_data);
endinterface

// File: rtl/pipe_sink.sv
// Tail consumer of a pipe_reg chain: FWFT buffer re-presenting words over valid/ready,
// with fill level and a saturating backpressure stall counter.
module pipe_sink #(
  parameter  int DSIZE = 8,
  parameter  int DEPTH = 4,
  parameter  int SW    = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          rst_n,
  pipe_sink_if.slave    bus,
  input  logic          flush,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic [SW-1:0] stall_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q;
  logic [SW-1:0]    stall_q;
  logic             push, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign stall_cnt = stall_q;

  // Only registered state and flush feed low_empty, so the chain never sees a
  // combinational loop through out_ready or up_valid.
  assign bus.low_empty = !full && !flush;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];

  assign push = bus.up_valid && bus.low_empty;
  assign pop  = bus.out_valid && bus.out_ready && !flush;

  // Storage is deliberately unreset; empty masks stale contents on out_data.
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= bus.up_data;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      stall_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      stall_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (bus.up_valid && !bus.low_empty && (stall_q != {SW{1'b1}}))
        stall_q <= stall_q + SW'(1);
    end
  end
endmodule

// File: tb/tb_pipe_sink.sv
// Directed bench for pipe_sink: stimulus queues expected head words, a negedge monitor
// pops and compares on every accepted handshake, register/flag checks run inline.
module tb_pipe_sink;
  localparam int DSIZE = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [LW-1:0]    level;
  logic             full, empty;
  logic [SW-1:0]    stall_cnt;
  logic [DSIZE-1:0] exp_q [$];
  logic [DSIZE-1:0] mon_exp;
  int               checks = 0;
  int               errors = 0;

  pipe_sink_if #(.DSIZE(DSIZE)) bus();

  pipe_sink #(.DSIZE(DSIZE), .DEPTH(DEPTH), .SW(SW)) dut (
    .clock(clock), .rst_n(rst_n), .bus(bus), .flush(flush),
    .level(level), .full(full), .empty(empty), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Inputs only change 1 time unit after a rising edge; checks happen there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [DSIZE-1:0] d);
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    exp_q.push_back(d);
  endtask

  always @(negedge clock) begin
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_extra got=%0h want=none", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", {24'd0, bus.out_data}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    bus.up_valid  = 1'b0;
    bus.up_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_low_empty", bus.low_empty, 1);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;

    // fill three, then a fourth to full
    push_word(8'h11); tick();
    push_word(8'h22); tick();
    push_word(8'h33); tick();
    chk("t1_level3", level, 3);
    chk("t1_head", bus.out_data, 8'h11);
    chk("t1_low_empty", bus.low_empty, 1);
    bus.up_valid = 1'b0;
    tick();
    push_word(8'h44); tick();
    chk("t1_full", full, 1);
    chk("t1_low_empty_full", bus.low_empty, 0);
    chk("t1_level4", level, 4);

    // full with pending 0x55: pop one, 0x55 accepted only on the following edge
    bus.up_data   = 8'h55;
    bus.out_ready = 1'b1;
    tick();
    chk("t2_low_empty", bus.low_empty, 1);
    chk("t2_level3", level, 3);
    chk("t2_head", bus.out_data, 8'h22);
    chk("t2_stall1", stall_cnt, 1);
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h55);
    tick();
    chk("t2_full_again", full, 1);
    bus.up_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("t2_empty", empty, 1);
    chk("t2_out_valid", bus.out_valid, 0);
    chk("t2_out_data", bus.out_data, 0);
    chk("t2_q_drained", exp_q.size(), 0);

    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_pre_stall0", stall_cnt, 0);

    // stall counting and saturation (SW=4 -> max 15)
    for (int i = 0; i < 4; i++) begin
      push_word(8'hA0 + 8'(i));
      tick();
    end
    bus.up_data = 8'hA4;
    repeat (10) tick();
    chk("t3_stall10", stall_cnt, 10);
    chk("t3_full", full, 1);
    repeat (10) tick();
    chk("t3_stall_sat", stall_cnt, 15);
    bus.up_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("t3_empty", empty, 1);
    chk("t3_stall_hold", stall_cnt, 15);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_flush_stall", stall_cnt, 0);

    // steady stream: level stays 1, head lags input by one edge
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_word(8'(i));
      tick();
      chk("t4_level", level, 1);
      chk("t4_head", bus.out_data, i);
    end
    bus.up_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("t4_empty", empty, 1);
    chk("t4_stall0", stall_cnt, 0);

    // flush at level 2 beats a ready downstream and a valid upstream
    push_word(8'hB1); tick();
    push_word(8'hB2); tick();
    bus.up_data   = 8'hB3;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("t5_level2", level, 2);
    chk("t5_low_empty_flush", bus.low_empty, 0);
    exp_q.delete();
    tick();
    chk("t5_level0", level, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_out_data", bus.out_data, 0);
    chk("t5_stall0", stall_cnt, 0);
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    push_word(8'hB3);
    #1;
    chk("t5_low_empty_after", bus.low_empty, 1);
    tick();
    bus.up_valid = 1'b0;
    chk("t5_level1", level, 1);
    chk("t5_head", bus.out_data, 8'hB3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // asynchronous reset mid-cycle at level 3
    push_word(8'hC1); tick();
    push_word(8'hC2); tick();
    push_word(8'hC3); tick();
    bus.up_valid = 1'b0;
    chk("t6_level3", level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_low_empty", bus.low_empty, 1);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_level0", level, 0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      push_word(8'hD0 + 8'(k));
      tick();
      bus.up_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("t6_head", bus.out_data, 8'hD0 + k);
      chk("t6_level1", level, 1);
      tick();
      bus.out_ready = 1'b0;
      chk("t6_empty", empty, 1);
    end
    chk("end_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
